mtimer_intr: RTL and testbench

- Memory-mapped RISC-V machine timer (mtime/mtimecmp) that raises the processor's timer-interrupt input t_intr.
- Sits on the processor's data-memory bus as a responder beside data_mem, using the same signals: rd_en, wr_en, addr, wdata, mem_mode.
- Reads are combinational so a single-cycle load completes in one cycle. Writes take effect at the clock edge.

---
 rtl/mtimer_pkg.sv | 19 +
 rtl/mtimer_tick_gen.sv | 36 +++
 rtl/mtimer_intr.sv | 113 +++++++++++
 tb/tb_mtimer_intr.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// mtimer_pkg : register map and CTRL field layout of the machine timer
// Revision   : 1.0
//------------------------------------------------------------------------------
package mtimer_pkg;
  localparam logic [3:0] OFF_MTIME_LO = 4'h0;
  localparam logic [3:0] OFF_MTIME_HI = 4'h1;
  localparam logic [3:0] OFF_CMP_LO   = 4'h2;
  localparam logic [3:0] OFF_CMP_HI   = 4'h3;
  localparam logic [3:0] OFF_CTRL     = 4'h4;
  localparam logic [3:0] OFF_STATUS   = 4'h5;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;

  localparam logic [2:0] MEM_WORD = 3'b010;
endpackage
`default_nettype wire

// File: rtl/mtimer_tick_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// mtimer_tick_gen : prescaler, one tick every DIV+1 enabled cycles
// Revision        : 1.0
//------------------------------------------------------------------------------
module mtimer_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             tick
);
  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign tick = en && (count_q == div);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clr || !en || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mtimer_intr.sv
`default_nettype none
//------------------------------------------------------------------------------
// mtimer_intr : memory-mapped mtime/mtimecmp timer driving the timer interrupt
// Revision    : 1.0
//------------------------------------------------------------------------------
module mtimer_intr
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DIV_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  mem_mode,
  output logic [31:0] rdata,
  output logic        t_intr
);
  logic             hit;
  logic [3:0]       off;
  logic             we;
  logic             tick;
  logic             ctrl_wr;
  logic [31:0]      ctrl_rd;

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q, cmp_d;
  logic             en_q, en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             t_intr_q, t_intr_d;

  assign hit    = (addr[31:6] == BASE_ADDR[31:6]) && (addr[1:0] == 2'b00);
  assign off    = addr[5:2];
  assign we     = wr_en && hit && (mem_mode == MEM_WORD);
  assign t_intr = t_intr_q;

  mtimer_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en_q),
    .div  (div_q),
    .clr  (ctrl_wr),
    .tick (tick)
  );

  always_comb begin
    ctrl_rd                          = '0;
    ctrl_rd[CTRL_EN_BIT]             = en_q;
    ctrl_rd[CTRL_DIV_LSB +: DIV_W]   = div_q;
  end

  // Reads see pre-edge state, so a same-cycle write returns the old value.
  always_comb begin
    rdata = '0;
    if (rd_en && hit) begin
      case (off)
        OFF_MTIME_LO: rdata = mtime_q[31:0];
        OFF_MTIME_HI: rdata = mtime_q[63:32];
        OFF_CMP_LO:   rdata = cmp_q[31:0];
        OFF_CMP_HI:   rdata = cmp_q[63:32];
        OFF_CTRL:     rdata = ctrl_rd;
        OFF_STATUS:   rdata = {31'b0, t_intr_q};
        default:      rdata = '0;
      endcase
    end
  end

  // A bus write to either mtime half overrides the tick increment.
  always_comb begin
    mtime_d  = tick ? (mtime_q + 64'd1) : mtime_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    div_d    = div_q;
    ctrl_wr  = 1'b0;
    if (we) begin
      case (off)
        OFF_MTIME_LO: mtime_d = {mtime_q[63:32], wdata};
        OFF_MTIME_HI: mtime_d = {wdata, mtime_q[31:0]};
        OFF_CMP_LO:   cmp_d   = {cmp_q[63:32], wdata};
        OFF_CMP_HI:   cmp_d   = {wdata, cmp_q[31:0]};
        OFF_CTRL: begin
          en_d    = wdata[CTRL_EN_BIT];
          div_d   = wdata[CTRL_DIV_LSB +: DIV_W];
          ctrl_wr = 1'b1;
        end
        default: ;
      endcase
    end
    t_intr_d = en_q && (mtime_q >= cmp_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q  <= 64'h0;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q     <= 1'b0;
      div_q    <= '0;
      t_intr_q <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      div_q    <= div_d;
      t_intr_q <= t_intr_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mtimer_intr.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_mtimer_intr : directed self-checking bench for mtimer_intr
// Revision       : 1.0
//------------------------------------------------------------------------------
module tb_mtimer_intr;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] A_MLO = BASE + 32'h00;
  localparam logic [31:0] A_MHI = BASE + 32'h04;
  localparam logic [31:0] A_CLO = BASE + 32'h08;
  localparam logic [31:0] A_CHI = BASE + 32'h0C;
  localparam logic [31:0] A_CTL = BASE + 32'h10;
  localparam logic [31:0] A_STS = BASE + 32'h14;
  localparam logic [2:0]  WORD  = 3'b010;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  mem_mode;
  logic [31:0] rdata;
  logic        t_intr;

  int          n_cmp;
  int          n_err;
  logic [31:0] d;
  logic        intr_s;

  mtimer_intr #(
    .BASE_ADDR (BASE),
    .DIV_W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .addr     (addr),
    .wdata    (wdata),
    .mem_mode (mem_mode),
    .rdata    (rdata),
    .t_intr   (t_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every bus task occupies exactly one clock cycle and returns at posedge+1.
  task automatic wr_mode(input logic [31:0] a, input logic [31:0] v, input logic [2:0] m);
    addr = a; wdata = v; mem_mode = m; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; mem_mode = WORD;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    wr_mode(a, v, WORD);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a; rd_en = 1'b1;
    #1;
    v = rdata; intr_s = t_intr;
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    wr(A_CHI, 32'h0); wr(A_CLO, 32'h0); wr(A_CTL, 32'h1);
    idle(2);
    n_cmp++; if (t_intr !== 1'b1) begin n_err++; $display("FAIL pre_reset_intr: got %b want 1", t_intr); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (t_intr !== 1'b0) begin n_err++; $display("FAIL async_reset_intr: got %b want 0", t_intr); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(A_MLO, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mtime_lo: got %h want 0", d); end
    rd(A_CLO, d);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_cmp_lo: got %h want ffffffff", d); end
    rd(A_CHI, d);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_cmp_hi: got %h want ffffffff", d); end
    rd(A_CTL, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", d); end
    n_cmp++; if (intr_s !== 1'b0) begin n_err++; $display("FAIL reset_intr: got %b want 0", intr_s); end
  endtask

  task automatic test_count_fire;
    wr(A_CHI, 32'h0); wr(A_CLO, 32'h5); wr(A_CTL, 32'h1);
    for (int i = 0; i < 9; i++) begin
      rd(A_MLO, d);
      n_cmp++; if (d !== 32'(i)) begin n_err++; $display("FAIL count_mtime[%0d]: got %h want %h", i, d, 32'(i)); end
      n_cmp++; if (intr_s !== (i >= 6)) begin n_err++; $display("FAIL count_intr[%0d]: got %b want %b", i, intr_s, (i >= 6)); end
    end
  endtask

  task automatic test_prescaler;
    wr(A_CTL, 32'h0000_0300); wr(A_MHI, 32'h0); wr(A_MLO, 32'h100); wr(A_CTL, 32'h0000_0301);
    for (int i = 0; i < 12; i++) begin
      rd(A_MLO, d);
      n_cmp++; if (d !== 32'h100 + 32'(i / 4)) begin n_err++; $display("FAIL presc_mtime[%0d]: got %h want %h", i, d, 32'h100 + 32'(i / 4)); end
      if (i == 0) begin
        n_cmp++; if (intr_s !== 1'b0) begin n_err++; $display("FAIL en_clear_intr: got %b want 0", intr_s); end
      end
    end
    rd(A_MLO, d); rd(A_MLO, d);
    wr(A_CTL, 32'h0000_0301);
    for (int j = 0; j < 5; j++) begin
      rd(A_MLO, d);
      n_cmp++; if (d !== ((j < 4) ? 32'h103 : 32'h104)) begin n_err++; $display("FAIL presc_restart[%0d]: got %h want %h", j, d, ((j < 4) ? 32'h103 : 32'h104)); end
    end
  endtask

  task automatic test_wrap;
    wr(A_CTL, 32'h0); wr(A_MHI, 32'h0); wr(A_MLO, 32'hFFFF_FFFF); wr(A_CTL, 32'h1); wr(A_CTL, 32'h0);
    rd(A_MHI, d);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL carry_hi: got %h want 1", d); end
    rd(A_MLO, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL carry_lo: got %h want 0", d); end
    wr(A_MHI, 32'hFFFF_FFFF); wr(A_MLO, 32'hFFFF_FFFF); wr(A_CTL, 32'h1); wr(A_CTL, 32'h0);
    rd(A_MHI, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL wrap_hi: got %h want 0", d); end
    rd(A_MLO, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL wrap_lo: got %h want 0", d); end
  endtask

  task automatic test_collision;
    wr(A_CTL, 32'h0); wr(A_MHI, 32'h0); wr(A_MLO, 32'h50); wr(A_CTL, 32'h1);
    wr(A_MHI, 32'h7);
    wr(A_MLO, 32'h10);
    rd(A_MLO, d);
    n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL collide_lo: got %h want 10", d); end
    rd(A_MHI, d);
    n_cmp++; if (d !== 32'h7) begin n_err++; $display("FAIL collide_hi: got %h want 7", d); end
    wr(A_CTL, 32'h0);
  endtask

  task automatic test_bus_filter;
    wr(A_MHI, 32'h0); wr(A_MLO, 32'h10);
    wr_mode(A_CTL, 32'h1, 3'b000);
    rd(A_CTL, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL sb_ctrl: got %h want 0", d); end
    wr(BASE + 32'h02, 32'h1234);
    rd(BASE + 32'h02, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL misaligned_rd: got %h want 0", d); end
    rd(A_MLO, d);
    n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL misaligned_wr: got %h want 10", d); end
    rd(BASE + 32'h20, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reserved_rd: got %h want 0", d); end
    wr(BASE + 32'h40, 32'h99);
    rd(A_MLO, d);
    n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL nonhit_wr: got %h want 10", d); end

    wr(A_CHI, 32'h0); wr(A_CLO, 32'h8); wr(A_CTL, 32'h0000_FF01);
    idle(1);
    rd(A_STS, d);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL status: got %h want 1", d); end
    rd(A_CTL, d);
    n_cmp++; if (d !== 32'h0000_FF01) begin n_err++; $display("FAIL ctrl_rb: got %h want 0000ff01", d); end

    addr = A_CLO; wdata = 32'h3; mem_mode = WORD; rd_en = 1'b1; wr_en = 1'b1;
    #1;
    n_cmp++; if (rdata !== 32'h8) begin n_err++; $display("FAIL rdwr_prewrite: got %h want 8", rdata); end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    rd(A_CLO, d);
    n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL rdwr_written: got %h want 3", d); end

    wr_mode(A_CLO, 32'hFFFF_FFFF, 3'b000);
    idle(1);
    n_cmp++; if (t_intr !== 1'b1) begin n_err++; $display("FAIL sb_cmp_intr: got %b want 1", t_intr); end
    wr(A_CHI, 32'h1);
    idle(1);
    n_cmp++; if (t_intr !== 1'b0) begin n_err++; $display("FAIL cmp_raise_intr: got %b want 0", t_intr); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    addr = '0; wdata = '0; mem_mode = WORD;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_count_fire;
    test_prescaler;
    test_wrap;
    test_collision;
    test_bus_filter;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
